// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Staged reset release for NUM_OUT clock/power domains once the PLL lock
//   indication has been stable for QUAL_CYC cycles. oRST is active-low per
//   domain and is released in ascending index order, one domain every
//   STEP_CYC cycles. oDONE is high only while every domain is released.
//
//   Optional feature macro: RSTSEQ_REVERSE_SHUTDOWN_EN
//     defined   : a software re-reset in RUN re-asserts the domains in
//                 descending order, one every STEP_CYC cycles (SHUTDOWN state).
//     undefined : a software re-reset in RUN re-asserts all domains at once.
module reset_sequencer #(
   parameter int NUM_OUT  = 3,
   parameter int QUAL_CYC = 16,
   parameter int STEP_CYC = 1024
) (
   input  logic               iCLK,
   input  logic               iRST,
   input  logic               iLOCK,
   input  logic               iSW_RST,
   output logic [NUM_OUT-1:0] oRST,
   output logic               oDONE
);

   // The single counter serves both the qualification and the step delays.
   localparam int CNT_MAX = (QUAL_CYC > STEP_CYC) ? QUAL_CYC : STEP_CYC;
   localparam int CNT_W   = $clog2((CNT_MAX > 1) ? CNT_MAX : 2);
   localparam int IDX_W   = $clog2((NUM_OUT > 1) ? NUM_OUT : 2);

   localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(QUAL_CYC - 1);
   localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_QUAL,
      S_RELEASE,
`ifdef RSTSEQ_REVERSE_SHUTDOWN_EN
      S_RUN,
      S_SHUTDOWN
`else
      S_RUN
`endif
   } state_t;

   logic [1:0]         r_sync;
   logic               w_lock_s;
   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [IDX_W-1:0]   r_idx;
   logic [NUM_OUT-1:0] r_rst;
   logic               r_done;

   assign w_lock_s = r_sync[1];
   assign oRST     = r_rst;
   assign oDONE    = r_done;

   // Two-flop synchronizer bringing the asynchronous lock indication into iCLK.
   always_ff @(posedge iCLK) begin
      // NOTE: reset here is synchronous and active-high, so it lives inside the
      // clocked block and is evaluated like any other data condition.
      if (iRST) begin
         r_sync <= 2'b00;
      end else begin
         r_sync <= {r_sync[0], iLOCK};
      end
   end

   // Sequencer FSM with registered outputs; oRST is shifted as a thermometer
   // code so it can only ever gain or lose its top released bit.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_rst   <= '0;
         r_done  <= 1'b0;
      end else if ((r_state != S_IDLE) && !w_lock_s) begin
         // Lock loss anywhere outside IDLE aborts immediately and wins over
         // a coincident software request.
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_rst   <= '0;
         r_done  <= 1'b0;
      end else begin
         // NOTE: every state register uses non-blocking assignment so all
         // fields update together from the values seen before this edge.
         case (r_state)
            S_IDLE: begin
               r_rst  <= '0;
               r_done <= 1'b0;
               if (w_lock_s) begin
                  r_state <= S_QUAL;
                  r_cnt   <= '0;
               end
            end

            S_QUAL: begin
               if (r_cnt == QUAL_LAST) begin
                  r_state <= S_RELEASE;
                  r_cnt   <= '0;
                  r_idx   <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            S_RELEASE: begin
               if (r_cnt == STEP_LAST) begin
                  r_rst <= NUM_OUT'({r_rst, 1'b1});
                  r_cnt <= '0;
                  if (r_idx == IDX_LAST) begin
                     r_state <= S_RUN;
                     r_done  <= 1'b1;
                  end else begin
                     r_idx <= r_idx + IDX_W'(1);
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            S_RUN: begin
               if (iSW_RST) begin
                  r_done <= 1'b0;
                  r_cnt  <= '0;
`ifdef RSTSEQ_REVERSE_SHUTDOWN_EN
                  // Top domain goes back into reset right away; lower ones
                  // follow one per step.
                  r_rst <= r_rst >> 1;
                  if (NUM_OUT == 1) begin
                     r_state <= S_IDLE;
                     r_idx   <= '0;
                  end else begin
                     r_state <= S_SHUTDOWN;
                     r_idx   <= IDX_W'(NUM_OUT - 2);
                  end
`else
                  r_rst   <= '0;
                  r_idx   <= '0;
                  r_state <= S_IDLE;
`endif
               end
            end

`ifdef RSTSEQ_REVERSE_SHUTDOWN_EN
            S_SHUTDOWN: begin
               if (r_cnt == STEP_LAST) begin
                  r_rst <= r_rst >> 1;
                  r_cnt <= '0;
                  if (r_idx == '0) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_idx <= r_idx - IDX_W'(1);
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
`endif

            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_idx   <= '0;
               r_rst   <= '0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
